// File: rtl/seg_pkg.sv
// Shared constants for seven-segment capture/check logic: legal hex patterns,
// blank pattern, digit count, capture FSM states and anode strobe helpers.
// Latency: n/a (package). Backpressure: n/a.
//
// Segment bit order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low patterns for hex digits 0..F.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // SEEK   : waiting for a single anode to be strobed
  // SETTLE : counting identical samples of the current strobe
  // HOLD   : digit already taken for this strobe period, wait for a change
  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // A strobe is legal when exactly one active-low anode is asserted.
  function automatic logic strobe_legal(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] sel;
    sel = ~an;
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment (active-low) to hex nibble lookup.
// Latency: 0 cycles (pure combinational). Backpressure: none.
//
// Ports:
//   i_seg : segment pattern {g,f,e,d,c,b,a}, active-low
//   o_nib : decoded nibble, 0 when the pattern is not a legal hex glyph
//   o_err : 1 when i_seg is not one of the 16 legal hex glyphs (blank included)
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_err
);

  always_comb begin
    o_nib = 4'h0;
    o_err = 1'b0;
    case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs the 4 hex digits shown on a multiplexed active-low 7-seg bus.
// Latency: 1 input register cycle, then STABLE_CYCLES identical samples per digit.
// Backpressure: out_valid/out_ready; a frame completing while out_valid is held
//   without out_ready replaces the pending frame and sets sticky overrun.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   seg         : segment bus {g,f,e,d,c,b,a}, active-low
//   an          : anode strobes, active-low, an[i]=0 selects digit i
//   out_ready   : consumer accepts the frame when high together with out_valid
//   out_valid   : frame available
//   out_digits  : {d3,d2,d1,d0}
//   out_err     : per-digit illegal-pattern flags
//   overrun     : sticky, a completed frame overwrote an unaccepted one
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_digits,
  output logic [3:0]  out_err,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Registered copy of the display bus; everything downstream uses this.
  logic [6:0]            r_seg;
  logic [3:0]            r_an;

  // Reference sample currently being qualified / held.
  logic [6:0]            r_ref_seg;
  logic [3:0]            r_ref_an;
  logic [CNT_W-1:0]      r_cnt;
  state_t                r_state;

  // Shadow frame being assembled and the mask of digits captured so far.
  logic [NUM_DIGITS-1:0] r_captured;
  logic [15:0]           r_shadow_dig;
  logic [3:0]            r_shadow_err;

  logic                  w_legal;
  logic                  w_match;
  logic [3:0]            w_sel;
  logic [3:0]            w_dec_nib;
  logic                  w_dec_err;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_start;
  logic                  w_capture;
  logic [NUM_DIGITS-1:0] w_captured_nxt;
  logic                  w_frame_done;
  logic [15:0]           w_shadow_dig_nxt;
  logic [3:0]            w_shadow_err_nxt;

  seg7_to_hex u_dec (
    .i_seg (r_seg),
    .o_nib (w_dec_nib),
    .o_err (w_dec_err)
  );

  assign w_legal   = strobe_legal(r_an);
  assign w_match   = (r_an == r_ref_an) && (r_seg == r_ref_seg);
  // With a legal strobe the inverted anodes are one-hot: the digit slot.
  assign w_sel     = ~r_an;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // A new reference is latched from SEEK, or reloaded in SETTLE when the
  // strobe changed to another legal value before qualifying.
  assign w_start = w_legal &&
                   ((r_state == SEEK) || ((r_state == SETTLE) && !w_match));

  // The reference is always a legal strobe, so w_match implies w_legal.
  // A freshly latched reference already counts as one sample, which only
  // qualifies on its own when a single sample is enough.
  assign w_capture = (w_start && (STABLE_CYCLES == 1)) ||
                     ((r_state == SETTLE) && w_match && (w_cnt_inc >= STABLE_CNT));

  always_comb begin
    w_shadow_dig_nxt = r_shadow_dig;
    w_shadow_err_nxt = r_shadow_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_capture && w_sel[i]) begin
        w_shadow_dig_nxt[i*4 +: 4] = w_dec_nib;
        w_shadow_err_nxt[i]        = w_dec_err;
      end
    end
  end

  assign w_captured_nxt = r_captured | (w_capture ? w_sel : 4'b0000);
  assign w_frame_done   = (w_captured_nxt == 4'hF);

  // Input register and capture FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg     <= SEG_BLANK;
      r_an      <= 4'hF;
      r_ref_seg <= SEG_BLANK;
      r_ref_an  <= 4'hF;
      r_cnt     <= '0;
      r_state   <= SEEK;
    end else begin
      r_seg <= seg;
      r_an  <= an;
      case (r_state)
        SEEK: begin
          if (w_legal) begin
            r_ref_seg <= r_seg;
            r_ref_an  <= r_an;
            r_cnt     <= CNT_ONE;
            r_state   <= w_capture ? HOLD : SETTLE;
          end
        end
        SETTLE: begin
          if (!w_legal) begin
            r_cnt   <= '0;
            r_state <= SEEK;
          end else if (w_match) begin
            r_cnt <= w_cnt_inc;
            if (w_capture) begin
              r_state <= HOLD;
            end
          end else begin
            r_ref_seg <= r_seg;
            r_ref_an  <= r_an;
            r_cnt     <= CNT_ONE;
            if (w_capture) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Any change ends the strobe period; the changed sample itself is
          // not used, SEEK picks up the bus again on the next sample.
          if (!w_match) begin
            r_cnt   <= '0;
            r_state <= SEEK;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= SEEK;
        end
      endcase
    end
  end

  // Shadow frame assembly and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_captured   <= '0;
      r_shadow_dig <= '0;
      r_shadow_err <= '0;
      out_valid    <= 1'b0;
      out_digits   <= '0;
      out_err      <= '0;
      overrun      <= 1'b0;
    end else begin
      r_shadow_dig <= w_shadow_dig_nxt;
      r_shadow_err <= w_shadow_err_nxt;
      r_captured   <= w_frame_done ? 4'h0 : w_captured_nxt;

      if (w_frame_done) begin
        // The newest frame always wins; dropping an unaccepted one is flagged.
        out_digits <= w_shadow_dig_nxt;
        out_err    <= w_shadow_err_nxt;
        out_valid  <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus random scans
// checked against a run-length reference model of the display bus.
// Latency/backpressure of the DUT are observed only through its ports.
module tb_seg_scan_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_digits;
  logic [3:0]  out_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_err    (out_err),
    .overrun    (overrun)
  );

  // Hex glyph table, index = nibble value.
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- reference model ----------------
  // A digit is taken once per run of identical samples, when the run reaches
  // STABLE samples. The first sample after a taken run is not counted.
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  bit          m_done;
  logic [3:0]  m_mask;
  logic [3:0]  m_dig [4];
  logic        m_err [4];
  logic        m_ovr;
  logic [19:0] exp_q [$];

  int          pulses = 0;
  logic [15:0] last_dig;
  logic [3:0]  last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == s) return {1'b0, 4'(k)};
    end
    return 5'b10000;
  endfunction

  task automatic model_reset();
    m_an   = 4'hF;
    m_seg  = 7'h7F;
    m_run  = 0;
    m_done = 0;
    m_mask = 4'h0;
    m_ovr  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0;
      m_err[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    logic [4:0]  dec;
    logic [19:0] frame;
    int          d;
    if ({a, s} != {m_an, m_seg}) begin
      m_run  = m_done ? 0 : 1;
      m_done = 0;
      m_an   = a;
      m_seg  = s;
    end else if (m_run < 100000) begin
      m_run++;
    end
    if (($countones(~a) == 1) && !m_done && (m_run == STABLE)) begin
      m_done = 1;
      d = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) d = i;
      dec = ref_decode(s);
      m_dig[d]  = dec[3:0];
      m_err[d]  = dec[4];
      m_mask[d] = 1'b1;
      if (m_mask == 4'hF) begin
        m_mask = 4'h0;
        frame = {m_err[3], m_err[2], m_err[1], m_err[0],
                 m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        if (!out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_back());
          m_ovr = 1'b1;
        end
        exp_q.push_back(frame);
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      an  = a;
      seg = s;
      model_step(a, s);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0, input int n);
    drive(4'b1110, s0, n);
    drive(4'b1101, s1, n);
    drive(4'b1011, s2, n);
    drive(4'b0111, s3, n);
    drive(4'b1111, 7'h7F, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Handshake monitor: every accepted frame must be the next one the model expects.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pulses++;
      last_dig = out_digits;
      last_err = out_err;
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("frame_content", 32'({out_err, out_digits}), 32'(exp_q.pop_front()));
      end
    end
  end

  int p0;
  logic [3:0] gap_an [5] = '{4'hF, 4'h0, 4'h3, 4'h5, 4'hC};

  initial begin
    rst       = 1'b1;
    an        = 4'hF;
    seg       = 7'h7F;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_valid",   32'(out_valid),  32'd0);
    check("rst_digits",  32'(out_digits), 32'h0);
    check("rst_err",     32'(out_err),    32'h0);
    check("rst_overrun", 32'(overrun),    32'd0);

    // Basic frame 4321, 6 cycles per digit.
    p0 = pulses;
    scan(pat[4], pat[3], pat[2], pat[1], 6);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_digits", 32'(last_dig),    32'h4321);
    check("t1_err",    32'(last_err),    32'h0);

    // Strobes too short to qualify.
    p0 = pulses;
    scan(pat[4], pat[3], pat[2], pat[1], 3);
    scan(pat[8], pat[7], pat[6], pat[5], 3);
    check("t2_pulses", 32'(pulses - p0), 32'd0);
    check("t2_valid",  32'(out_valid),   32'd0);

    // Blank on digit 2.
    p0 = pulses;
    scan(pat[12], 7'h7F, pat[11], pat[10], 6);
    check("t3_pulses", 32'(pulses - p0), 32'd1);
    check("t3_digits", 32'(last_dig),    32'hC0BA);
    check("t3_err",    32'(last_err),    32'b0100);

    // Two anodes low is a gap; partial frame survives it.
    p0 = pulses;
    drive(4'b1110, pat[5], 6);
    drive(4'b1101, pat[6], 6);
    drive(4'b1011, pat[7], 6);
    drive(4'b0011, pat[9], 10);
    check("t5_no_frame", 32'(pulses - p0), 32'd0);
    drive(4'b0111, pat[8], 6);
    drive(4'b1111, 7'h7F, 4);
    check("t5_pulses", 32'(pulses - p0), 32'd1);
    check("t5_digits", 32'(last_dig),    32'h8765);

    // Overrun: two frames while the consumer stalls; newest wins.
    p0 = pulses;
    out_ready = 1'b0;
    scan(pat[1], pat[1], pat[1], pat[1], 6);
    scan(pat[2], pat[2], pat[2], pat[2], 6);
    check("t4_valid",   32'(out_valid),    32'd1);
    check("t4_digits",  32'(out_digits),   32'h2222);
    check("t4_err",     32'(out_err),      32'h0);
    check("t4_overrun", 32'(overrun),      32'(m_ovr));
    check("t4_stall",   32'(pulses - p0),  32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_drop",    32'(out_valid),    32'd0);
    check("t4_pulses",  32'(pulses - p0),  32'd1);
    out_ready = 1'b1;

    // Reset after 3 captured digits discards them and clears overrun.
    p0 = pulses;
    drive(4'b1110, pat[1], 6);
    drive(4'b1101, pat[2], 6);
    drive(4'b1011, pat[3], 6);
    do_reset();
    check("t6_valid",   32'(out_valid), 32'd0);
    check("t6_overrun", 32'(overrun),   32'd0);
    scan(pat[11], pat[14], pat[14], pat[15], 6);
    check("t6_pulses",  32'(pulses - p0), 32'd1);
    check("t6_digits",  32'(last_dig),    32'hBEEF);
    check("t6_err",     32'(last_err),    32'h0);

    // Random scans with random holds, gaps, illegal glyphs and recaptures.
    for (int it = 0; it < 40; it++) begin
      for (int dd = 0; dd < 4; dd++) begin
        logic [3:0] a;
        logic [6:0] s;
        a = ~(4'b0001 << dd);
        s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat[$urandom_range(0, 15)];
        drive(a, s, $urandom_range(2, 8));
        if ($urandom_range(0, 5) == 0) begin
          a = ~(4'b0001 << $urandom_range(0, 3));
          drive(a, pat[$urandom_range(0, 15)], $urandom_range(3, 7));
        end
        if ($urandom_range(0, 3) == 0) begin
          drive(gap_an[$urandom_range(0, 4)], 7'($urandom), $urandom_range(1, 3));
        end
      end
    end
    drive(4'hF, 7'h7F, 8);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_overrun", 32'(overrun),      32'(m_ovr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
